grf_sb: RTL and testbench
=========================

// Module: grf_sb
// PURPOSE
//   Parametrised general register file for the pipelined MIPS core.
//   Adds N read ports, optional write-through bypass, a per-register busy
//   scoreboard for hazard stalls, and a registered write-trace port.
//   Sits between ID (reads and issues) and WB (writes back).
//   Replaces the fixed 2-read, 32x32 register file.
// PARAMETERS
//   DW      32  data width, in bits
//   AW      5   address width; depth is 2**AW registers
//   NRD     2   number of read ports
//   BYPASS  1   1: a same-cycle write is visible on the read data; 0: read old value
// PORTS
//   clk        in   1        rising-edge clock
//   reset      in   1        asynchronous, active-high reset
//   we         in   1        write enable (WB stage)
//   wa         in   AW       write address
//   wd         in   DW       write data
//   wpc        in   32       PC of the writing instruction (trace only)
//   ra         in   NRD*AW   packed read addresses; port k = ra[k*AW +: AW]
//   rd         out  NRD*DW   packed read data; port k = rd[k*DW +: DW]
//   rbusy      out  NRD      port k reads a register that has a pending write
//   iss        in   1        issue: mark register iss_dst as pending
//   iss_dst    in   AW       destination register of the issuing instruction
//   tr_valid   out  1        write-trace valid, one-cycle pulse
//   tr_addr    out  AW       traced register address
//   tr_data    out  DW       traced write data
//   tr_pc      out  32       traced PC
// BEHAVIOUR
//   Reset (async, asserted): every register = 0, every busy bit = 0,
//     tr_valid = 0, tr_addr = 0, tr_data = 0, tr_pc = 0.
//   Register 0: always reads 0. A write to it is discarded: no state change, no trace.
//     It is never marked busy.
//   Write: on posedge clk with we=1 and wa!=0, reg[wa] <= wd.
//   Read: combinational, zero latency.
//     rd[k] = 0 if ra[k] == 0.
//     rd[k] = wd if BYPASS and we and wa == ra[k] and wa != 0.
//     Otherwise rd[k] = reg[ra[k]].
//   Scoreboard: one busy bit per register, updated on posedge clk.
//     Set when iss=1 and iss_dst != 0.
//     Cleared when we=1 and wa != 0.
//     Set and clear on the same register in the same cycle -> bit stays set
//       (the younger issue wins).
//     A set and a clear on different registers in the same cycle are both applied.
//     rbusy[k] = busy[ra[k]] and ra[k] != 0.
//       If BYPASS, a write in the current cycle to ra[k] masks rbusy[k] to 0,
//       unless iss targets the same register in that cycle.
//   Trace: registered; reflects the write accepted in the previous cycle.
//     After a cycle with we=1 and wa != 0:
//       tr_valid = 1; tr_addr/tr_data/tr_pc = wa/wd/wpc.
//     Otherwise tr_valid = 0; addr/data/pc hold their last values.
//   Reset mid-operation: pending writes are lost, the scoreboard clears and the
//     trace drops immediately (asynchronously).
//   Address width: wa, ra and iss_dst are always in range; there is no
//     out-of-range case.
// TESTING
//   1. Reset, then read all 32 registers on both ports -> every rd = 0, rbusy = 0, tr_valid = 0.
//   2. we=1, wa=5, wd=0x1234_5678, wpc=0x3000, ra0=5.
//      -> BYPASS=1: rd0 = 0x12345678 in the same cycle.
//         BYPASS=0: rd0 = 0 in that cycle, 0x12345678 in the next.
//      -> Next cycle: tr_valid=1, tr_addr=5, tr_data=0x12345678, tr_pc=0x3000.
//   3. we=1, wa=0, wd=0xFFFF_FFFF -> reg0 still reads 0, tr_valid stays 0;
//      iss=1, iss_dst=0 -> rbusy stays 0.
//   4. iss=1, iss_dst=8; next cycle ra1=8 -> rbusy1=1.
//      Then we=1, wa=8, iss=1, iss_dst=8 in the same cycle -> busy[8] remains 1.
//      Then write 8 again with no issue -> busy[8] = 0.
//   5. Write reg 3 = 0xAA, set busy on reg 9.
//      Assert reset between clock edges -> reg3 = 0 and rbusy = 0 immediately,
//      tr_valid = 0, with no clock edge needed.
//   6. NRD=4, DW=16 build: distinct addresses 1..4 written with 0x0101..0x0404
//      -> each port returns its own value; packed slices are correctly ordered.

Source files
------------

// File: rtl/grf_sb.sv
// General register file with N read ports, optional write-through bypass,
// a per-register busy scoreboard and a registered write-trace port.
module grf_sb #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [DW-1:0]       wd,
    input  logic [31:0]         wpc,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*DW-1:0]   rd,
    output logic [NRD-1:0]      rbusy,
    input  logic                iss,
    input  logic [AW-1:0]       iss_dst,
    output logic                tr_valid,
    output logic [AW-1:0]       tr_addr,
    output logic [DW-1:0]       tr_data,
    output logic [31:0]         tr_pc
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    regs [0:DEPTH-1];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             wr_en;
    logic             iss_en;

    // Register 0 is hardwired: writes and issues targeting it are ignored.
    assign wr_en  = we && (wa != '0);
    assign iss_en = iss && (iss_dst != '0);

    // Clear first, then set, so a same-cycle issue to the written register wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_en)
            busy_nxt[wa] = 1'b0;
        if (iss_en)
            busy_nxt[iss_dst] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            busy     <= '0;
            tr_valid <= 1'b0;
            tr_addr  <= '0;
            tr_data  <= '0;
            tr_pc    <= '0;
        end else begin
            if (wr_en)
                regs[wa] <= wd;
            busy     <= busy_nxt;
            tr_valid <= wr_en;
            if (wr_en) begin
                tr_addr <= wa;
                tr_data <= wd;
                tr_pc   <= wpc;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;
        assign a   = ra[k*AW +: AW];
        assign hit = (BYPASS != 0) && wr_en && (wa == a);
        assign rd[k*DW +: DW] = (a == '0) ? '0 : (hit ? wd : regs[a]);
        // A bypassed write retires the hazard unless a new issue re-claims the register.
        assign rbusy[k] = (a != '0) && busy[a] && !(hit && !(iss_en && (iss_dst == a)));
    end

endmodule

// File: tb/tb_grf_sb.sv
// Self-checking bench for grf_sb: directed table, reset/width corner cases,
// and randomized traffic against a behavioural register-file model.
module tb_grf_sb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 0, iss = 0;
    logic [4:0]  wa = 0, iss_dst = 0;
    logic [31:0] wd = 0, wpc = 0;
    logic [9:0]  ra = 0;
    logic [63:0] rd;
    logic [1:0]  rbusy;
    logic        tr_valid;
    logic [4:0]  tr_addr;
    logic [31:0] tr_data, tr_pc;

    logic        w_we = 0, w_iss = 0;
    logic [4:0]  w_wa = 0, w_iss_dst = 0;
    logic [15:0] w_wd = 0;
    logic [31:0] w_wpc = 0;
    logic [19:0] w_ra = 0;
    logic [63:0] w_rd;
    logic [3:0]  w_rbusy;
    logic        w_tr_valid;
    logic [4:0]  w_tr_addr;
    logic [15:0] w_tr_data;
    logic [31:0] w_tr_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    grf_sb u_dut (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .wpc(wpc),
        .ra(ra), .rd(rd), .rbusy(rbusy), .iss(iss), .iss_dst(iss_dst),
        .tr_valid(tr_valid), .tr_addr(tr_addr), .tr_data(tr_data), .tr_pc(tr_pc)
    );

    grf_sb #(.DW(16), .AW(5), .NRD(4), .BYPASS(0)) u_wide (
        .clk(clk), .reset(reset), .we(w_we), .wa(w_wa), .wd(w_wd), .wpc(w_wpc),
        .ra(w_ra), .rd(w_rd), .rbusy(w_rbusy), .iss(w_iss), .iss_dst(w_iss_dst),
        .tr_valid(w_tr_valid), .tr_addr(w_tr_addr), .tr_data(w_tr_data), .tr_pc(w_tr_pc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd, wpc;
        logic [4:0]  ra0, ra1;
        logic        iss;
        logic [4:0]  dst;
        logic [31:0] e_rd0, e_rd1;
        logic [1:0]  e_rb;
        logic        e_tv;
        logic [4:0]  e_ta;
        logic [31:0] e_td, e_tp;
    } vec_t;

    vec_t tbl [11];

    // Behavioural model: plain arrays holding what the register file should contain.
    logic [31:0] m_reg [32];
    bit          m_busy [32];
    logic        m_tv;
    logic [4:0]  m_ta;
    logic [31:0] m_td, m_tp;

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (we && wa == a) return wd;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        bit written, reissued;
        if (a == 0) return 1'b0;
        written  = we && (wa == a);
        reissued = iss && (iss_dst == a);
        if (written && !reissued) return 1'b0;
        return m_busy[a];
    endfunction

    initial begin
        tbl[0]  = '{1, 5, 32'h12345678, 32'h3000, 5, 0, 0, 0, 32'h12345678, 0, 2'b00, 1, 5, 32'h12345678, 32'h3000};
        tbl[1]  = '{1, 0, 32'hFFFFFFFF, 32'h4000, 0, 5, 1, 0, 0, 32'h12345678, 2'b00, 0, 5, 32'h12345678, 32'h3000};
        tbl[2]  = '{0, 0, 0, 0, 8, 5, 1, 8, 0, 32'h12345678, 2'b00, 0, 5, 32'h12345678, 32'h3000};
        tbl[3]  = '{0, 0, 0, 0, 5, 8, 0, 0, 32'h12345678, 0, 2'b10, 0, 5, 32'h12345678, 32'h3000};
        tbl[4]  = '{1, 8, 32'hBEEF, 32'h3010, 5, 8, 1, 8, 32'h12345678, 32'hBEEF, 2'b10, 1, 8, 32'hBEEF, 32'h3010};
        tbl[5]  = '{0, 0, 0, 0, 5, 8, 0, 0, 32'h12345678, 32'hBEEF, 2'b10, 0, 8, 32'hBEEF, 32'h3010};
        tbl[6]  = '{1, 8, 32'hCAFE, 32'h3020, 8, 8, 0, 0, 32'hCAFE, 32'hCAFE, 2'b00, 1, 8, 32'hCAFE, 32'h3020};
        tbl[7]  = '{0, 0, 0, 0, 8, 5, 0, 0, 32'hCAFE, 32'h12345678, 2'b00, 0, 8, 32'hCAFE, 32'h3020};
        tbl[8]  = '{1, 8, 32'h11, 32'h3030, 10, 8, 1, 10, 0, 32'h11, 2'b00, 1, 8, 32'h11, 32'h3030};
        tbl[9]  = '{0, 0, 0, 0, 10, 8, 0, 0, 0, 32'h11, 2'b01, 0, 8, 32'h11, 32'h3030};
        tbl[10] = '{1, 10, 32'h22, 32'h3040, 10, 8, 0, 0, 32'h22, 32'h11, 2'b00, 1, 10, 32'h22, 32'h3040};

        // Reset and sweep every register on both ports.
        repeat (2) @(negedge clk);
        chk("reset_tr_valid", tr_valid, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        for (int a = 0; a < 32; a++) begin
            ra = {5'(31 - a), 5'(a)};
            #1;
            chk($sformatf("reset_rd0_r%0d", a), rd[31:0], 0);
            chk($sformatf("reset_rd1_r%0d", 31 - a), rd[63:32], 0);
            chk("reset_rbusy", rbusy, 0);
        end
        chk("reset_tr_valid2", tr_valid, 0);
        chk("reset_tr_addr", tr_addr, 0);
        chk("reset_tr_data", tr_data, 0);
        chk("reset_tr_pc", tr_pc, 0);

        // Directed table: bypass, reg0 writes, scoreboard set/clear ordering, trace.
        for (int i = 0; i < 11; i++) begin
            we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd; wpc = tbl[i].wpc;
            ra = {tbl[i].ra1, tbl[i].ra0}; iss = tbl[i].iss; iss_dst = tbl[i].dst;
            #1;
            chk($sformatf("v%0d_rd0", i), rd[31:0], tbl[i].e_rd0);
            chk($sformatf("v%0d_rd1", i), rd[63:32], tbl[i].e_rd1);
            chk($sformatf("v%0d_rbusy", i), rbusy, tbl[i].e_rb);
            @(posedge clk); #1;
            chk($sformatf("v%0d_tr_valid", i), tr_valid, tbl[i].e_tv);
            chk($sformatf("v%0d_tr_addr", i), tr_addr, tbl[i].e_ta);
            chk($sformatf("v%0d_tr_data", i), tr_data, tbl[i].e_td);
            chk($sformatf("v%0d_tr_pc", i), tr_pc, tbl[i].e_tp);
        end

        // Asynchronous reset between edges wipes data, scoreboard and trace.
        we = 1; wa = 3; wd = 32'hAA; wpc = 32'h5000; iss = 1; iss_dst = 9;
        @(posedge clk); #1;
        we = 0; iss = 0; ra = {5'd9, 5'd3};
        #1;
        chk("pre_rst_rd0", rd[31:0], 32'hAA);
        chk("pre_rst_rbusy", rbusy, 2'b10);
        chk("pre_rst_tv", tr_valid, 1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_rd0", rd[31:0], 0);
        chk("async_rst_rbusy", rbusy, 0);
        chk("async_rst_tv", tr_valid, 0);
        chk("async_rst_taddr", tr_addr, 0);
        @(negedge clk);
        reset = 1'b0;

        // Wide build, no bypass: same-cycle read returns the old value, slices ordered.
        @(posedge clk); #1;
        w_we = 1; w_wa = 1; w_wd = 16'h0101; w_ra = {5'd0, 5'd0, 5'd0, 5'd1};
        #1;
        chk("wide_nobypass_same", w_rd[15:0], 0);
        @(posedge clk); #1;
        chk("wide_nobypass_next", w_rd[15:0], 16'h0101);
        chk("wide_tr_valid", w_tr_valid, 1);
        w_wa = 2; w_wd = 16'h0202; w_iss = 1; w_iss_dst = 4;
        @(posedge clk); #1;
        w_wa = 3; w_wd = 16'h0303; w_iss = 0;
        @(posedge clk); #1;
        w_wa = 4; w_wd = 16'h0404; w_ra = {5'd4, 5'd0, 5'd0, 5'd0};
        #1;
        chk("wide_rbusy_unmasked", w_rbusy, 4'b1000);
        chk("wide_rd3_old", w_rd[63:48], 0);
        @(posedge clk); #1;
        w_we = 0;
        w_ra = {5'd4, 5'd3, 5'd2, 5'd1};
        #1;
        for (int k = 0; k < 4; k++)
            chk($sformatf("wide_fwd_p%0d", k), w_rd[k*16 +: 16], 64'(16'h0101 * (k + 1)));
        chk("wide_rbusy_clear", w_rbusy, 0);
        w_ra = {5'd1, 5'd2, 5'd3, 5'd4};
        #1;
        for (int k = 0; k < 4; k++)
            chk($sformatf("wide_rev_p%0d", k), w_rd[k*16 +: 16], 64'(16'h0101 * (4 - k)));

        // Randomized traffic against the model; addresses often confined to a small window.
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = 0;
            m_busy[i] = 0;
        end
        m_tv = 0; m_ta = 0; m_td = 0; m_tp = 0;
        for (int n = 0; n < 400; n++) begin
            bit narrow;
            narrow  = ($urandom_range(0, 3) != 0);
            we      = $urandom_range(0, 1);
            iss     = $urandom_range(0, 1);
            wa      = narrow ? 5'($urandom_range(0, 6)) : 5'($urandom);
            iss_dst = narrow ? 5'($urandom_range(0, 6)) : 5'($urandom);
            ra      = narrow ? {5'($urandom_range(0, 6)), 5'($urandom_range(0, 6))} : 10'($urandom);
            wd      = $urandom;
            wpc     = $urandom;
            #1;
            chk("rnd_rd0", rd[31:0], exp_rd(ra[4:0]));
            chk("rnd_rd1", rd[63:32], exp_rd(ra[9:5]));
            chk("rnd_rbusy", rbusy, {exp_busy(ra[9:5]), exp_busy(ra[4:0])});
            @(posedge clk);
            m_tv = we && (wa != 0);
            if (m_tv) begin
                m_reg[wa] = wd;
                m_busy[wa] = 0;
                m_ta = wa; m_td = wd; m_tp = wpc;
            end
            if (iss && iss_dst != 0)
                m_busy[iss_dst] = 1;
            #1;
            chk("rnd_tr_valid", tr_valid, m_tv);
            chk("rnd_tr_addr", tr_addr, m_ta);
            chk("rnd_tr_data", tr_data, m_td);
            chk("rnd_tr_pc", tr_pc, m_tp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
